rgb_duty_fader: RTL and testbench
=================================

Name: rgb_duty_fader

Overview:
Upstream duty-cycle source for the RGB LED comparator stage. Generates the free-running PWM counter and three per-channel duty values consumed by the `counter < duty` comparators. It accepts new colour targets over a valid/ready handshake and ramps each channel linearly toward its target. Duty registers change only at PWM period boundaries, so LED outputs never glitch mid-period.

Parameters:
PWM_WIDTH, 10, width of counter and duty values.
PERIOD_MAX, 1023, terminal count; counter runs 0..PERIOD_MAX then wraps to 0. Must be at most 2^PWM_WIDTH-1.
STEP_PERIODS, 4, number of PWM periods between fade steps; must be at least 1.
STEP_SIZE, 8, maximum duty change per channel per step; must be at least 1.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
target_valid  input  1  target triple offered
target_ready  output  1  block can accept a target
target_red  input  PWM_WIDTH  red target duty
target_green  input  PWM_WIDTH  green target duty
target_blue  input  PWM_WIDTH  blue target duty
pwm_counter  output  PWM_WIDTH  free-running PWM counter
pwm_red  output  PWM_WIDTH  current red duty
pwm_green  output  PWM_WIDTH  current green duty
pwm_blue  output  PWM_WIDTH  current blue duty
period_start  output  1  one-cycle pulse in each cycle where pwm_counter wraps to 0
fade_busy  output  1  high while a fade is in progress

Behaviour:
- Reset (rst_n low, asynchronous): all of the following take effect immediately, including mid-fade. Any in-flight target is discarded.
  - pwm_counter=0, pwm_red/green/blue=0.
  - period_start=0, fade_busy=0, target_ready=0.
  - Target registers=0, step counter=0, state=IDLE.
- pwm_counter: increments every clk. At PERIOD_MAX it loads 0 (the wrap). period_start is registered and is high exactly in the cycles where pwm_counter==0 following a wrap. There is no pulse in the first period after reset.
- target_ready is registered and is high only in IDLE. It rises on the first clk edge after rst_n deasserts.
- FSM states are IDLE and FADE.
  - IDLE: on target_valid && target_ready, capture the three targets, clear the step counter, and enter FADE.
  - If the captured triple equals the current duties, return to IDLE on the next cycle with no duty change.
  - FADE: target_ready=0 and fade_busy=1. target_valid is ignored; there is no retargeting mid-fade.
  - At each wrap, if step counter == STEP_PERIODS-1, apply a step and clear the counter; otherwise increment the counter.
- Step rule, per channel:
  - If duty < target: duty = min(duty+STEP_SIZE, target).
  - If duty > target: duty = max(duty-STEP_SIZE, target).
  - If equal: no change.
  - Compute in PWM_WIDTH+1 bits so there is no overflow or underflow; results always clamp exactly to the target.
- Duty registers update on the same edge where pwm_counter goes to 0. The new duty is therefore in effect for the whole of the next period.
- After a step that leaves all three channels equal to their targets, the FSM returns to IDLE on the following cycle. target_ready is high one cycle after the final duty update.
- Channels fade independently. A channel already at its target holds its value while the others continue.
- Latency: the first step occurs at the STEP_PERIODS-th wrap after acceptance. A fade needs ceil(max |delta| / STEP_SIZE) steps.

Test Plan:
Use PERIOD_MAX=15, STEP_PERIODS=2, STEP_SIZE=4 unless stated otherwise.
1. Release reset and run 40 cycles -> pwm_counter goes 0..15,0,...; duties stay 0; period_start pulses at each return to 0 except the first period; target_ready goes to 1 one cycle after release.
2. From 0, send target (10,0,15) -> red steps 4,8,10 and blue steps 4,8,12,15 at every 2nd wrap; green stays 0; fade_busy clears and target_ready returns after the blue step to 15.
3. Send (10,10,10) from (10,10,10) -> fade_busy high for exactly one cycle; no duty change.
4. From (10,0,0), send target (3,0,0) -> red goes 6, then 3 (clamped, not 2); never drops below 3.
5. Hold target_valid with a new triple during a FADE -> not accepted until target_ready rises; the new triple is captured on that handshake cycle.
6. Assert rst_n low mid-period during a FADE -> all outputs go to reset values immediately without waiting for clk; after release, no residual fade resumes.
7. Check with PERIOD_MAX=1023, STEP_PERIODS=4, STEP_SIZE=8 -> for red 0->1023 every duty change coincides with pwm_counter==0; the final value is 1023 after 128 steps.

Source files
------------

// File: rtl/rgb_duty_fader.sv
// rtl/rgb_duty_fader.sv - free-running PWM counter with per-channel linear duty fader
// Duties move only on counter wrap, so downstream counter<duty comparators never glitch mid-period.
module rgb_duty_fader #(
  parameter int PWM_WIDTH    = 10,
  parameter int PERIOD_MAX   = 1023,
  parameter int STEP_PERIODS = 4,
  parameter int STEP_SIZE    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 target_valid,
  output logic                 target_ready,
  input  logic [PWM_WIDTH-1:0] target_red,
  input  logic [PWM_WIDTH-1:0] target_green,
  input  logic [PWM_WIDTH-1:0] target_blue,
  output logic [PWM_WIDTH-1:0] pwm_counter,
  output logic [PWM_WIDTH-1:0] pwm_red,
  output logic [PWM_WIDTH-1:0] pwm_green,
  output logic [PWM_WIDTH-1:0] pwm_blue,
  output logic                 period_start,
  output logic                 fade_busy
);

  localparam int W    = PWM_WIDTH;
  localparam int SC_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic [W-1:0]    PMAX    = W'(PERIOD_MAX);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STEP_PERIODS - 1);
  localparam logic [W:0]      STEP    = (W+1)'(STEP_SIZE);

  typedef enum logic {IDLE, FADE} state_t;

  state_t          state;
  logic [W-1:0]    tgt_red, tgt_green, tgt_blue;
  logic [SC_W-1:0] step_cnt;
  logic            wrap;
  logic            at_target;

  assign wrap      = (pwm_counter == PMAX);
  assign at_target = (pwm_red == tgt_red) && (pwm_green == tgt_green) && (pwm_blue == tgt_blue);

  // One extra bit keeps cur+STEP and cur-tgt free of wraparound, so the clamp is exact.
  function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur, input logic [W-1:0] tgt);
    logic [W:0] c, t, d;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    step_toward = cur;
    if (c < t) begin
      d = c + STEP;
      step_toward = (d >= t) ? tgt : d[W-1:0];
    end else if (c > t) begin
      d = c - t;
      step_toward = (d <= STEP) ? tgt : cur - STEP[W-1:0];
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_counter  <= '0;
      pwm_red      <= '0;
      pwm_green    <= '0;
      pwm_blue     <= '0;
      period_start <= 1'b0;
      fade_busy    <= 1'b0;
      target_ready <= 1'b0;
      tgt_red      <= '0;
      tgt_green    <= '0;
      tgt_blue     <= '0;
      step_cnt     <= '0;
      state        <= IDLE;
    end else begin
      pwm_counter  <= wrap ? '0 : pwm_counter + 1'b1;
      period_start <= wrap;
      case (state)
        IDLE: begin
          if (target_valid && target_ready) begin
            tgt_red      <= target_red;
            tgt_green    <= target_green;
            tgt_blue     <= target_blue;
            step_cnt     <= '0;
            state        <= FADE;
            target_ready <= 1'b0;
            fade_busy    <= 1'b1;
          end else begin
            target_ready <= 1'b1;
          end
        end
        FADE: begin
          if (at_target) begin
            state        <= IDLE;
            target_ready <= 1'b1;
            fade_busy    <= 1'b0;
          end else if (wrap) begin
            if (step_cnt == SC_LAST) begin
              step_cnt  <= '0;
              pwm_red   <= step_toward(pwm_red, tgt_red);
              pwm_green <= step_toward(pwm_green, tgt_green);
              pwm_blue  <= step_toward(pwm_blue, tgt_blue);
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_duty_fader.sv
// tb/tb_rgb_duty_fader.sv - self-checking bench for rgb_duty_fader
// Small-period instance against a closed-form fade model, plus a full-size-step instance for long ramps.
module tb_rgb_duty_fader;

  localparam int P_MAX = 15;
  localparam int SP    = 2;
  localparam int SS    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       target_valid = 1'b0;
  logic       target_ready;
  logic [9:0] target_red = '0, target_green = '0, target_blue = '0;
  logic [9:0] pwm_counter, pwm_red, pwm_green, pwm_blue;
  logic       period_start, fade_busy;

  logic       rst2_n = 1'b0;
  logic       tv2 = 1'b0;
  logic       ready2;
  logic [9:0] tr2 = '0;
  logic [9:0] cnt2, red2, green2, blue2;
  logic       ps2, busy2;

  always #5 clk = ~clk;

  rgb_duty_fader #(.PWM_WIDTH(10), .PERIOD_MAX(P_MAX), .STEP_PERIODS(SP), .STEP_SIZE(SS)) dut (
    .clk(clk), .rst_n(rst_n), .target_valid(target_valid), .target_ready(target_ready),
    .target_red(target_red), .target_green(target_green), .target_blue(target_blue),
    .pwm_counter(pwm_counter), .pwm_red(pwm_red), .pwm_green(pwm_green), .pwm_blue(pwm_blue),
    .period_start(period_start), .fade_busy(fade_busy));

  rgb_duty_fader #(.PWM_WIDTH(10), .PERIOD_MAX(63), .STEP_PERIODS(4), .STEP_SIZE(8)) dut2 (
    .clk(clk), .rst_n(rst2_n), .target_valid(tv2), .target_ready(ready2),
    .target_red(tr2), .target_green(10'd0), .target_blue(10'd0),
    .pwm_counter(cnt2), .pwm_red(red2), .pwm_green(green2), .pwm_blue(blue2),
    .period_start(ps2), .fade_busy(busy2));

  int n_cmp = 0;
  int n_fail = 0;
  int n_printed = 0;
  bit done2 = 1'b0;

  // Model: duty after k steps is base moved toward target by k*SS, clamped.
  int m_cnt, m_duty[3], m_base[3], m_tgt[3], m_wraps;
  bit m_ps, m_busy, m_ready, m_idle, m_accepted;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int move(input int base, input int tgt, input int amt);
    if (tgt > base) return (base + amt > tgt) ? tgt : base + amt;
    else            return (base - amt < tgt) ? tgt : base - amt;
  endfunction

  function automatic void model_reset();
    m_cnt = 0; m_ps = 0; m_busy = 0; m_ready = 0; m_idle = 1; m_wraps = 0; m_accepted = 0;
    for (int c = 0; c < 3; c++) begin m_duty[c] = 0; m_base[c] = 0; m_tgt[c] = 0; end
  endfunction

  task automatic tick();
    bit wrap;
    logic [42:0] exp_v, act_v;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      wrap = (m_cnt == P_MAX);
      m_cnt = wrap ? 0 : m_cnt + 1;
      m_ps = wrap;
      m_accepted = 0;
      if (m_idle) begin
        if (target_valid && m_ready) begin
          m_tgt[0] = int'(target_red); m_tgt[1] = int'(target_green); m_tgt[2] = int'(target_blue);
          for (int c = 0; c < 3; c++) m_base[c] = m_duty[c];
          m_wraps = 0; m_idle = 0; m_ready = 0; m_busy = 1; m_accepted = 1;
        end else m_ready = 1;
      end else if (m_duty[0] == m_tgt[0] && m_duty[1] == m_tgt[1] && m_duty[2] == m_tgt[2]) begin
        m_idle = 1; m_ready = 1; m_busy = 0;
      end else if (wrap) begin
        m_wraps++;
        if (m_wraps % SP == 0)
          for (int c = 0; c < 3; c++) m_duty[c] = move(m_base[c], m_tgt[c], (m_wraps / SP) * SS);
      end
    end
    #1;
    exp_v = {10'(m_cnt), 10'(m_duty[0]), 10'(m_duty[1]), 10'(m_duty[2]), m_ps, m_busy, m_ready};
    act_v = {pwm_counter, pwm_red, pwm_green, pwm_blue, period_start, fade_busy, target_ready};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_fail++;
      if (n_printed < 20) $display("FAIL cycle: got %h expected %h at %0t", act_v, exp_v, $time);
      n_printed++;
    end
  endtask

  task automatic run_target(input int r, input int g, input int b,
                            output int steps, output int busy_cyc, output int min_red);
    int guard;
    logic [29:0] prev;
    target_red = 10'(r); target_green = 10'(g); target_blue = 10'(b);
    target_valid = 1'b1;
    guard = 0;
    do begin tick(); guard++; end while (!m_accepted && guard < 3000);
    target_valid = 1'b0;
    if (!m_accepted) check("accept_timeout", 0, 1);
    steps = 0; busy_cyc = int'(fade_busy); min_red = int'(pwm_red);
    prev = {pwm_red, pwm_green, pwm_blue};
    guard = 0;
    while (!target_ready && guard < 3000) begin
      tick(); guard++;
      if ({pwm_red, pwm_green, pwm_blue} != prev) steps++;
      prev = {pwm_red, pwm_green, pwm_blue};
      busy_cyc += int'(fade_busy);
      if (int'(pwm_red) < min_red) min_red = int'(pwm_red);
    end
    if (!target_ready) check("ready_timeout", 0, 1);
  endtask

  typedef struct {int r; int g; int b; int exp_steps;} vec_t;
  vec_t vecs[7];

  initial begin
    int steps, busy_cyc, min_red, exp_steps, maxd, d;
    model_reset();
    vecs[0] = '{10, 0, 15, 4};
    vecs[1] = '{10, 10, 10, 3};
    vecs[2] = '{10, 10, 10, 0};
    vecs[3] = '{10, 0, 0, 3};
    vecs[4] = '{3, 0, 0, 2};
    vecs[5] = '{15, 15, 15, 4};
    vecs[6] = '{0, 15, 0, 4};

    #2;
    check("reset_outputs", int'({pwm_counter, pwm_red, pwm_green, pwm_blue, period_start, fade_busy, target_ready}), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("ready_after_release", int'(target_ready), 1);
    repeat (40) tick();

    foreach (vecs[i]) begin
      run_target(vecs[i].r, vecs[i].g, vecs[i].b, steps, busy_cyc, min_red);
      check($sformatf("steps_row%0d", i), steps, vecs[i].exp_steps);
      check($sformatf("final_row%0d", i), int'({pwm_red, pwm_green, pwm_blue}),
            (vecs[i].r << 20) | (vecs[i].g << 10) | vecs[i].b);
      if (vecs[i].exp_steps == 0) check("noop_busy_cycles", busy_cyc, 1);
      if (vecs[i].r == 3) check("clamp_min_red", min_red, 3);
      repeat (3) tick();
    end

    // Triple held on target_valid during a fade waits for the next handshake.
    target_red = 10'd0; target_green = 10'd0; target_blue = 10'd0; target_valid = 1'b1;
    for (int k = 0; k < 100 && !m_accepted; k++) tick();
    target_red = 10'd7; target_green = 10'd9; target_blue = 10'd11;
    tick();
    for (int k = 0; k < 3000 && !m_accepted; k++) tick();
    check("held_accept_from_zero", int'({pwm_red, pwm_green, pwm_blue}), 0);
    target_valid = 1'b0;
    for (int k = 0; k < 3000 && !target_ready; k++) tick();
    check("held_final", int'({pwm_red, pwm_green, pwm_blue}), (7 << 20) | (9 << 10) | 11);

    for (int n = 0; n < 6; n++) begin
      int r, g, b;
      r = int'($urandom_range(0, 15)); g = int'($urandom_range(0, 15)); b = int'($urandom_range(0, 15));
      maxd = 0;
      d = r - m_duty[0]; if (d < 0) d = -d; if (d > maxd) maxd = d;
      d = g - m_duty[1]; if (d < 0) d = -d; if (d > maxd) maxd = d;
      d = b - m_duty[2]; if (d < 0) d = -d; if (d > maxd) maxd = d;
      exp_steps = (maxd + SS - 1) / SS;
      repeat ($urandom_range(0, 20)) tick();
      run_target(r, g, b, steps, busy_cyc, min_red);
      check("rand_steps", steps, exp_steps);
      check("rand_final", int'({pwm_red, pwm_green, pwm_blue}), (r << 20) | (g << 10) | b);
    end

    // Asynchronous reset mid-period during a fade.
    target_red = 10'd15; target_green = 10'd0; target_blue = 10'd15; target_valid = 1'b1;
    for (int k = 0; k < 100 && !m_accepted; k++) tick();
    target_valid = 1'b0;
    repeat (45) tick();
    check("fade_in_progress", int'(fade_busy), 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'({pwm_counter, pwm_red, pwm_green, pwm_blue, period_start, fade_busy, target_ready}), 0);
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (80) tick();
    check("no_residual_fade", int'({pwm_red, pwm_green, pwm_blue, fade_busy}), 0);

    for (int k = 0; k < 50000 && !done2; k++) tick();
    check("long_fade_done", int'(done2), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    int steps2, off_edge, guard;
    bit rdy;
    logic [9:0] prev;
    repeat (3) @(posedge clk);
    #1 rst2_n = 1'b1;
    tr2 = 10'd1023; tv2 = 1'b1;
    guard = 0;
    do begin rdy = ready2; @(posedge clk); #1; guard++; end while (!rdy && guard < 100);
    tv2 = 1'b0;
    steps2 = 0; off_edge = 0; prev = red2; guard = 0;
    while (!ready2 && guard < 40000) begin
      @(posedge clk); #1; guard++;
      if (red2 != prev) begin
        steps2++;
        if (cnt2 != 10'd0) off_edge++;
      end
      prev = red2;
    end
    check("long_steps", steps2, 128);
    check("long_off_boundary", off_edge, 0);
    check("long_final", int'({red2, green2, blue2}), 1023 << 20);
    done2 = 1'b1;
  end

endmodule
